irq_controller: RTL and testbench



---
 rtl/irq_controller.sv | 134 +++++++++++++
 tb/tb_irq_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// Eight-source interrupt controller: latches event pulses as pending flags, arbitrates
// by programmable 2-bit priority and hands one vector at a time to the CPU.
module irq_controller #(
    parameter logic [23:0] BASE_ADDR   = 24'h2020,
    parameter logic [7:0]  VECTOR_BASE = 8'h08
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic [7:0]  irq_in,
    input  logic [1:0]  cpu_level,
    output logic        irq_req,
    output logic [7:0]  irq_vector,
    input  logic        irq_ack
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] REQ  = 1'b1;

    logic [7:0]  prio_lo;
    logic [7:0]  prio_hi;
    logic [7:0]  enable;
    logic [7:0]  pending;
    logic [0:0]  state;
    logic [2:0]  sel;
    logic [1:0]  sel_prio;

    logic [15:0] prio_all;
    logic        hit_prio_lo;
    logic        hit_prio_hi;
    logic        hit_enable;
    logic        hit_pending;
    logic        found;
    logic [2:0]  winner;
    logic [1:0]  best_prio;
    logic        req_valid;
    logic [1:0]  cur_sel_prio;
    logic        withdraw;
    logic        accept;
    logic [7:0]  clr;

    // Reads have no side effects, so the read strobe is not needed.
    logic unused_bus_read;
    assign unused_bus_read = bus_read;

    assign prio_all    = {prio_hi, prio_lo};
    assign hit_prio_lo = (bus_address_in == BASE_ADDR);
    assign hit_prio_hi = (bus_address_in == BASE_ADDR + 24'd1);
    assign hit_enable  = (bus_address_in == BASE_ADDR + 24'd3);
    assign hit_pending = (bus_address_in == BASE_ADDR + 24'd7);

    always_comb begin
        bus_data_out = 8'h00;
        if (hit_prio_lo)      bus_data_out = prio_lo;
        else if (hit_prio_hi) bus_data_out = prio_hi;
        else if (hit_enable)  bus_data_out = enable;
        else if (hit_pending) bus_data_out = pending;
    end

    // Strict greater-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        found     = 1'b0;
        winner    = 3'd0;
        best_prio = 2'd0;
        for (int i = 0; i < 8; i++) begin
            if (pending[i] && enable[i] && (prio_all[2*i +: 2] > best_prio)) begin
                found     = 1'b1;
                winner    = 3'(i);
                best_prio = prio_all[2*i +: 2];
            end
        end
    end

    assign req_valid    = found && (best_prio > cpu_level);
    assign cur_sel_prio = prio_all[{sel, 1'b0} +: 2];
    assign withdraw     = !pending[sel] || !enable[sel] || (cur_sel_prio == 2'd0)
                          || (cpu_level >= sel_prio);
    assign accept       = (state == REQ) && irq_ack;
    assign clr          = ((bus_write && hit_pending) ? bus_data_in : 8'h00)
                          | (accept ? (8'h01 << sel) : 8'h00);

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_lo <= 8'h00;
            prio_hi <= 8'h00;
            enable  <= 8'h00;
            pending <= 8'h00;
        end else begin
            if (bus_write && hit_prio_lo) prio_lo <= bus_data_in;
            if (bus_write && hit_prio_hi) prio_hi <= bus_data_in;
            if (bus_write && hit_enable)  enable  <= bus_data_in;
            // A new event always beats a clear landing on the same edge.
            pending <= (pending & ~clr) | irq_in;
        end
    end

    // Once a request is raised its source and vector stay frozen until ack or withdraw.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= 3'd0;
            sel_prio   <= 2'd0;
            irq_req    <= 1'b0;
            irq_vector <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        state      <= REQ;
                        sel        <= winner;
                        sel_prio   <= best_prio;
                        irq_vector <= VECTOR_BASE + {5'd0, winner};
                        irq_req    <= 1'b1;
                    end
                end
                REQ: begin
                    if (irq_ack || withdraw) begin
                        state   <= IDLE;
                        irq_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    irq_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: handshake, arbitration, masking, clears and reset.
module tb_irq_controller;

    localparam logic [23:0] BASE = 24'h2020;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        bus_write = 1'b0;
    logic        bus_read = 1'b0;
    logic [23:0] bus_address_in = 24'h0;
    logic [7:0]  bus_data_in = 8'h0;
    logic [7:0]  bus_data_out;
    logic [7:0]  irq_in = 8'h0;
    logic [1:0]  cpu_level = 2'd0;
    logic        irq_req;
    logic [7:0]  irq_vector;
    logic        irq_ack = 1'b0;

    int compared = 0;
    int mismatched = 0;

    irq_controller #(.BASE_ADDR(BASE), .VECTOR_BASE(8'h08)) dut (
        .clk(clk),
        .reset(reset),
        .bus_write(bus_write),
        .bus_read(bus_read),
        .bus_address_in(bus_address_in),
        .bus_data_in(bus_data_in),
        .bus_data_out(bus_data_out),
        .irq_in(irq_in),
        .cpu_level(cpu_level),
        .irq_req(irq_req),
        .irq_vector(irq_vector),
        .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    // Drive one cycle of irq_in/irq_ack, then land 1 time unit after the edge.
    task automatic applyStimulus(input logic [7:0] irq, input logic ack);
        irq_in  = irq;
        irq_ack = ack;
        @(posedge clk);
        #1;
        irq_in  = 8'h00;
        irq_ack = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%02h expected=0x%02h", tag, observed, expected);
        end
    endtask

    task automatic writeReg(input logic [2:0] offset, input logic [7:0] data,
                            input logic [7:0] irq);
        bus_write      = 1'b1;
        bus_address_in = BASE + {21'd0, offset};
        bus_data_in    = data;
        applyStimulus(irq, 1'b0);
        bus_write      = 1'b0;
    endtask

    task automatic checkReg(input string tag, input logic [2:0] offset,
                            input logic [7:0] expected);
        bus_address_in = BASE + {21'd0, offset};
        #1;
        checkOutput(tag, bus_data_out, expected);
    endtask

    initial begin
        $display("[TB] starting irq_controller bench");
        reset = 1'b1;
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        reset = 1'b0;
        checkOutput("rst_req", {7'd0, irq_req}, 8'h00);
        checkOutput("rst_vec", irq_vector, 8'h00);
        checkReg("rst_prio_lo", 3'd0, 8'h00);
        checkReg("rst_enable", 3'd3, 8'h00);
        checkReg("rst_pending", 3'd7, 8'h00);

        // Basic handshake on source 3.
        writeReg(3'd3, 8'h08, 8'h00);
        writeReg(3'd0, 8'hC0, 8'h00);
        applyStimulus(8'h08, 1'b0);
        checkOutput("hs_req_cycle1", {7'd0, irq_req}, 8'h00);
        checkReg("hs_pending", 3'd7, 8'h08);
        applyStimulus(8'h00, 1'b0);
        checkOutput("hs_req_cycle2", {7'd0, irq_req}, 8'h01);
        checkOutput("hs_vec", irq_vector, 8'h0B);
        applyStimulus(8'h00, 1'b1);
        checkOutput("hs_req_after_ack", {7'd0, irq_req}, 8'h00);
        checkReg("hs_pending_after_ack", 3'd7, 8'h00);

        // Priority order and lowest-index tie-break.
        writeReg(3'd0, 8'h28, 8'h00);
        writeReg(3'd1, 8'h04, 8'h00);
        writeReg(3'd3, 8'hFF, 8'h00);
        checkReg("prio_hi_readback", 3'd1, 8'h04);
        checkReg("unmapped_read", 3'd2, 8'h00);
        applyStimulus(8'h26, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("tie_req1", {7'd0, irq_req}, 8'h01);
        checkOutput("tie_vec1", irq_vector, 8'h09);
        applyStimulus(8'h00, 1'b1);
        checkOutput("tie_gap", {7'd0, irq_req}, 8'h00);
        applyStimulus(8'h00, 1'b0);
        checkOutput("tie_req2", {7'd0, irq_req}, 8'h01);
        checkOutput("tie_vec2", irq_vector, 8'h0A);
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'h00, 1'b0);
        checkOutput("tie_req3", {7'd0, irq_req}, 8'h01);
        checkOutput("tie_vec3", irq_vector, 8'h0D);
        applyStimulus(8'h00, 1'b1);
        checkReg("tie_pending_done", 3'd7, 8'h00);

        // Level masking on source 0 (priority 2).
        writeReg(3'd0, 8'h02, 8'h00);
        cpu_level = 2'd2;
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("mask_blocked", {7'd0, irq_req}, 8'h00);
        cpu_level = 2'd1;
        applyStimulus(8'h00, 1'b0);
        checkOutput("mask_open_req", {7'd0, irq_req}, 8'h01);
        checkOutput("mask_open_vec", irq_vector, 8'h08);
        cpu_level = 2'd3;
        applyStimulus(8'h00, 1'b0);
        checkOutput("mask_withdraw", {7'd0, irq_req}, 8'h00);
        checkReg("mask_pending_kept", 3'd7, 8'h01);
        writeReg(3'd7, 8'h01, 8'h00);
        checkReg("mask_w1c", 3'd7, 8'h00);

        // Software clear withdraws the request for source 4.
        writeReg(3'd1, 8'h03, 8'h00);
        cpu_level = 2'd0;
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("w1c_req", {7'd0, irq_req}, 8'h01);
        checkOutput("w1c_vec", irq_vector, 8'h0C);
        writeReg(3'd7, 8'h10, 8'h00);
        checkReg("w1c_pending", 3'd7, 8'h00);
        applyStimulus(8'h00, 1'b0);
        checkOutput("w1c_withdrawn", {7'd0, irq_req}, 8'h00);
        checkOutput("w1c_vec_held", irq_vector, 8'h0C);
        writeReg(3'd7, 8'h10, 8'h10);
        checkReg("w1c_set_wins", 3'd7, 8'h10);

        // Ack collides with a fresh event on the selected source.
        applyStimulus(8'h00, 1'b0);
        checkOutput("col_req", {7'd0, irq_req}, 8'h01);
        applyStimulus(8'h10, 1'b1);
        checkOutput("col_req_low", {7'd0, irq_req}, 8'h00);
        checkReg("col_pending", 3'd7, 8'h10);
        applyStimulus(8'h00, 1'b0);
        checkOutput("col_reassert", {7'd0, irq_req}, 8'h01);
        checkOutput("col_vec", irq_vector, 8'h0C);

        // Reset while requesting, with an ack in the same cycle.
        reset = 1'b1;
        applyStimulus(8'h00, 1'b1);
        reset = 1'b0;
        checkOutput("mid_rst_req", {7'd0, irq_req}, 8'h00);
        checkOutput("mid_rst_vec", irq_vector, 8'h00);
        checkReg("mid_rst_prio_lo", 3'd0, 8'h00);
        checkReg("mid_rst_prio_hi", 3'd1, 8'h00);
        checkReg("mid_rst_enable", 3'd3, 8'h00);
        checkReg("mid_rst_pending", 3'd7, 8'h00);
        applyStimulus(8'h10, 1'b0);
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h00, 1'b0);
        checkOutput("post_rst_no_req", {7'd0, irq_req}, 8'h00);
        checkReg("post_rst_pending", 3'd7, 8'h10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
